// File: rtl/slow_clock_monitor.sv
// ============================================================================
// Module   : slow_clock_monitor
// Brief    : Syncs a divided slow clock into IN_CLK, emits edge strobes,
//            measures its period and tracks lock / period error / timeout.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module slow_clock_monitor #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 26,
    parameter int EXP_PERIOD  = 33554432,
    parameter int TOL         = 16,
    parameter int LOCK_COUNT  = 4
) (
    input  logic             IN_CLK,
    input  logic             RST,
    input  logic             SLOW_CLK,
    output logic             TICK,
    output logic             FALL_TICK,
    output logic [CNT_W-1:0] PERIOD,
    output logic             PERIOD_VALID,
    output logic             LOCKED,
    output logic             PERIOD_ERR,
    output logic             TIMEOUT
);

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    // Tolerance window and timeout threshold, one bit wider than the counter.
    localparam logic [CNT_W:0] c_tol_hi  = (CNT_W+1)'(EXP_PERIOD + TOL);
    localparam logic [CNT_W:0] c_tol_lo  = (EXP_PERIOD > TOL) ?
                                           (CNT_W+1)'(EXP_PERIOD - TOL) : '0;
    localparam logic [CNT_W:0] c_timeout = c_tol_hi + (CNT_W+1)'(1);
    localparam logic [3:0]     c_lock    = 4'(LOCK_COUNT);

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_d;
    logic [CNT_W-1:0]       cnt;
    logic [3:0]             good_cnt;

    logic             s;
    logic             rise;
    logic             fall;
    logic [CNT_W:0]   cnt_ext;
    logic             in_tol;
    logic             at_thr;

    always_comb begin
        s       = sync_q[SYNC_STAGES-1];
        rise    = s & ~s_d;
        fall    = ~s & s_d;
        cnt_ext = {1'b0, cnt};
        in_tol  = (cnt_ext >= c_tol_lo) && (cnt_ext <= c_tol_hi);
        at_thr  = (cnt_ext == c_timeout);
    end

    always_ff @(posedge IN_CLK) begin
        if (RST) begin
            sync_q       <= '0;
            s_d          <= 1'b0;
            cnt          <= '0;
            good_cnt     <= '0;
            PERIOD       <= '0;
            TICK         <= 1'b0;
            FALL_TICK    <= 1'b0;
            PERIOD_VALID <= 1'b0;
            PERIOD_ERR   <= 1'b0;
            TIMEOUT      <= 1'b0;
            LOCKED       <= 1'b0;
            state        <= ST_SEARCH;
        end else begin
            sync_q       <= {sync_q[SYNC_STAGES-2:0], SLOW_CLK};
            s_d          <= s;
            TICK         <= rise;
            FALL_TICK    <= fall;
            PERIOD_VALID <= 1'b0;
            PERIOD_ERR   <= 1'b0;
            TIMEOUT      <= 1'b0;
            // LOCKED trails the state register so it changes the cycle after its cause.
            LOCKED       <= (state == ST_LOCKED);

            if (rise) begin
                cnt <= CNT_W'(1);
            end else if (cnt != {CNT_W{1'b1}}) begin
                cnt <= cnt + CNT_W'(1);
            end

            if (rise && (state != ST_SEARCH)) begin
                PERIOD       <= cnt;
                PERIOD_VALID <= 1'b1;
            end

            unique case (state)
                ST_SEARCH: begin
                    if (rise) begin
                        good_cnt <= '0;
                        state    <= ST_MEASURE;
                    end
                end
                ST_MEASURE: begin
                    if (rise) begin
                        if (in_tol) begin
                            good_cnt <= good_cnt + 4'd1;
                            if ((good_cnt + 4'd1) == c_lock) begin
                                state <= ST_LOCKED;
                            end
                        end else begin
                            good_cnt <= '0;
                        end
                    end else if (at_thr) begin
                        TIMEOUT  <= 1'b1;
                        good_cnt <= '0;
                        state    <= ST_SEARCH;
                    end
                end
                ST_LOCKED: begin
                    if (rise) begin
                        if (!in_tol) begin
                            PERIOD_ERR <= 1'b1;
                            good_cnt   <= '0;
                            state      <= ST_MEASURE;
                        end
                    end else if (at_thr) begin
                        TIMEOUT  <= 1'b1;
                        good_cnt <= '0;
                        state    <= ST_SEARCH;
                    end
                end
                default: begin
                    good_cnt <= '0;
                    state    <= ST_SEARCH;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_slow_clock_monitor.sv
// ============================================================================
// Module   : tb_slow_clock_monitor
// Brief    : Directed vector table plus hand sequences for slow_clock_monitor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_slow_clock_monitor;

    localparam int CNT_W = 8;
    localparam int NVEC  = 67;

    logic             clk  = 1'b0;
    logic             rst  = 1'b1;
    logic             slow = 1'b0;
    logic             tick;
    logic             fall_tick;
    logic [CNT_W-1:0] period;
    logic             pv;
    logic             locked;
    logic             perr;
    logic             tout;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic rst;
        logic slow;
        logic tick;
        logic fall;
        logic pv;
        logic locked;
        logic [CNT_W-1:0] period;
    } vec_t;

    vec_t vecs [NVEC];

    always #5 clk = ~clk;

    slow_clock_monitor #(
        .SYNC_STAGES (2),
        .CNT_W       (CNT_W),
        .EXP_PERIOD  (16),
        .TOL         (1),
        .LOCK_COUNT  (3)
    ) dut (
        .IN_CLK       (clk),
        .RST          (rst),
        .SLOW_CLK     (slow),
        .TICK         (tick),
        .FALL_TICK    (fall_tick),
        .PERIOD       (period),
        .PERIOD_VALID (pv),
        .LOCKED       (locked),
        .PERIOD_ERR   (perr),
        .TIMEOUT      (tout)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic s);
        @(posedge clk);
        #1;
        rst  = r;
        slow = s;
        @(negedge clk);
    endtask

    // One SLOW_CLK period of p cycles starting with a rise; the TICK of that
    // rise reports the previous period.
    task automatic run_period(input string name, input int p, input logic e_pv,
                              input int e_per, input logic e_err,
                              input logic e_lk_tick, input logic e_lk_next);
        int n_tick = 0;
        int n_pv   = 0;
        for (int i = 0; i < p; i++) begin
            step(1'b0, (i < p / 2));
            if (tick) n_tick++;
            if (pv)   n_pv++;
            if (i == 3) begin
                chk({name, ".tick"},   tick,   1);
                chk({name, ".pv"},     pv,     e_pv);
                chk({name, ".period"}, period, e_per);
                chk({name, ".err"},    perr,   e_err);
                chk({name, ".tout"},   tout,   0);
                chk({name, ".lk_tick"}, locked, e_lk_tick);
            end
            if (i == 4) chk({name, ".lk_next"}, locked, e_lk_next);
        end
        chk({name, ".n_tick"}, n_tick, 1);
        chk({name, ".n_pv"},   n_pv,   e_pv);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_to;
        int to_at;
        int n_pv;

        // Reset 3 cycles, then SLOW_CLK toggles every 8 cycles (rises at 3,19,35,51).
        for (int c = 0; c < NVEC; c++) begin
            vecs[c].rst    = (c < 3);
            vecs[c].slow   = (c >= 3) && ((((c - 3) / 8) % 2) == 0);
            vecs[c].tick   = (c == 6)  || (c == 22) || (c == 38) || (c == 54);
            vecs[c].fall   = (c == 14) || (c == 30) || (c == 46) || (c == 62);
            vecs[c].pv     = (c == 22) || (c == 38) || (c == 54);
            vecs[c].locked = (c >= 55);
            vecs[c].period = (c >= 22) ? 8'd16 : 8'd0;
        end

        for (int c = 0; c < NVEC; c++) begin
            step(vecs[c].rst, vecs[c].slow);
            chk($sformatf("vec%0d.tick", c),   tick,      vecs[c].tick);
            chk($sformatf("vec%0d.fall", c),   fall_tick, vecs[c].fall);
            chk($sformatf("vec%0d.pv", c),     pv,        vecs[c].pv);
            chk($sformatf("vec%0d.locked", c), locked,    vecs[c].locked);
            chk($sformatf("vec%0d.period", c), period,    vecs[c].period);
            chk($sformatf("vec%0d.err", c),    perr,      0);
            chk($sformatf("vec%0d.tout", c),   tout,      0);
        end

        // Tolerance edges while locked, error on 18, re-lock.
        run_period("p15",     15, 1, 16, 0, 1, 1);
        run_period("p17",     17, 1, 15, 0, 1, 1);
        run_period("p18",     18, 1, 17, 0, 1, 1);
        run_period("err18",   16, 1, 18, 1, 1, 0);
        run_period("relock1", 16, 1, 16, 0, 0, 0);
        run_period("relock2", 16, 1, 16, 0, 0, 0);
        run_period("relock3", 16, 1, 16, 0, 0, 1);

        // SLOW_CLK stops: one timeout 21 cycles after the last rise, then silence.
        n_to  = 0;
        to_at = -1;
        n_pv  = 0;
        for (int k = 16; k < 300; k++) begin
            step(1'b0, 1'b0);
            if (tout) begin
                n_to++;
                to_at = k;
            end
            if (pv) n_pv++;
            if (k == 21) chk("to.lk_at", locked, 1);
            if (k == 22) chk("to.lk_next", locked, 0);
        end
        chk("to.count",  n_to,   1);
        chk("to.cycle",  to_at,  21);
        chk("to.pv",     n_pv,   0);
        chk("to.period", period, 16);
        chk("to.locked", locked, 0);

        // From SEARCH; then a period of exactly the threshold: tick wins.
        run_period("srch1",    16, 0, 16, 0, 0, 0);
        run_period("thr_a",    18, 1, 16, 0, 0, 0);
        run_period("thr_tick", 16, 1, 18, 0, 0, 0);
        run_period("m1",       16, 1, 16, 0, 0, 0);
        run_period("m2",       16, 1, 16, 0, 0, 0);

        // Reset mid-measurement.
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        chk("rst.period", period, 0);
        chk("rst.locked", locked, 0);
        chk("rst.tick",   tick,   0);
        chk("rst.pv",     pv,     0);
        run_period("rs1", 16, 0, 0,  0, 0, 0);
        run_period("rs2", 16, 1, 16, 0, 0, 0);
        run_period("rs3", 16, 1, 16, 0, 0, 0);
        run_period("rs4", 16, 1, 16, 0, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
